dct_da_sequencer: RTL



---
 rtl/dct_da_pkg.sv | 21 ++
 rtl/dct_da_term_sel.sv | 26 ++
 rtl/dct_da_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/dct_da_pkg.sv
// dct_da_pkg: shared types and constants for the 4-point DCT distributed-
// arithmetic sequencer (state encoding, ROM address width, default widths
// and the accumulator-width helper).
package dct_da_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ADDR_W     = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ROM_W  = 16;

  // Accumulator must hold ROM_W-bit terms scaled by DATA_W bit-plane weights.
  function automatic int acc_w(input int data_w, input int rom_w);
    return data_w + rom_w;
  endfunction

endpackage

// File: rtl/dct_da_term_sel.sv
// dct_da_term_sel: combinational address mirroring and conditional negation
// for one bit plane of the DA evaluation.
//   i_plane    : {x0[j], x1[j], x2[j], x3[j]}
//   i_rom_data : ROM word for o_rom_addr (same cycle)
//   o_rom_addr : ROM address, mirrored when x0[j] is set
//   o_term     : signed partial sum, ROM_W+1 bits so negation never overflows
module dct_da_term_sel
  import dct_da_pkg::*;
#(
  parameter int ROM_W = DEF_ROM_W
) (
  input  logic [3:0]              i_plane,
  input  logic [ROM_W-1:0]        i_rom_data,
  output logic [ADDR_W-1:0]       o_rom_addr,
  output logic signed [ROM_W:0]   o_term
);

  logic signed [ROM_W:0] w_ext;

  // The ROM only stores the half with x0[j]=0; the other half is the
  // bitwise-complement address with the sign flipped.
  assign w_ext      = {i_rom_data[ROM_W-1], i_rom_data};
  assign o_rom_addr = i_plane[3] ? ~i_plane[2:0] : i_plane[2:0];
  assign o_term     = i_plane[3] ? -w_ext : w_ext;

endmodule

// File: rtl/dct_da_sequencer.sv
// dct_da_sequencer: bit-serial DA controller for one output row of a 4-point
// DCT. Latches x0..x3, walks their bit planes MSB to LSB, addresses an
// external mirrored coefficient ROM and shift-accumulates the partial sums.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : sample-set handshake, x0..x3 sampled at acceptance
//   rom_cs / rom_addr    : ROM select and address; rom_data returns same cycle
//   out_valid / out_ready: result handshake, result held while stalled
// Optional build macro DCT_DA_ROM_PIPE_EN registers the ROM term, adding one
// cycle of latency with bit-identical results.
module dct_da_sequencer
  import dct_da_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROM_W  = DEF_ROM_W,
  parameter int ACC_W  = acc_w(DATA_W, ROM_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  state_t                   r_state, w_state_nxt;
  logic                     r_settle;
  logic [3:0][DATA_W-1:0]   r_x;
  logic [CNT_W-1:0]         r_cnt;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nxt, w_term_ext;
  logic [ACC_W-1:0]         r_result;
  logic                     r_out_valid;

  logic                     w_accept;
  logic [3:0]               w_plane;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [ROM_W:0]    w_term;
  logic                     w_addr_act;   // ROM address phase this cycle
  logic                     w_acc_act;    // accumulate phase this cycle
  logic                     w_acc_msb;
  logic                     w_acc_last;
  logic signed [ROM_W:0]    w_acc_term;

  assign in_ready  = r_settle & (r_state == IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_plane   = {r_x[0][r_cnt], r_x[1][r_cnt], r_x[2][r_cnt], r_x[3][r_cnt]};
  assign rom_cs    = w_addr_act;
  assign rom_addr  = w_addr_act ? w_addr : '0;
  assign out_valid = r_out_valid;
  assign result    = r_result;

  dct_da_term_sel #(.ROM_W(ROM_W)) u_term_sel (
    .i_plane    (w_plane),
    .i_rom_data (rom_data),
    .o_rom_addr (w_addr),
    .o_term     (w_term)
  );

`ifdef DCT_DA_ROM_PIPE_EN
  // Address phase leads accumulate phase by one cycle; r_adone marks that
  // the LSB plane has been addressed and only its accumulate remains.
  logic                  r_adone, r_pv, r_msb, r_last;
  logic signed [ROM_W:0] r_term;

  assign w_addr_act = (r_state == RUN) & ~r_adone;
  assign w_acc_act  = (r_state == RUN) & r_pv;
  assign w_acc_term = r_term;
  assign w_acc_msb  = r_msb;
  assign w_acc_last = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adone <= 1'b0;
      r_pv    <= 1'b0;
      r_msb   <= 1'b0;
      r_last  <= 1'b0;
      r_term  <= '0;
    end else begin
      r_pv <= w_addr_act;
      if (w_addr_act) begin
        r_term <= w_term;
        r_msb  <= (r_cnt == CNT_TOP);
        r_last <= (r_cnt == '0);
      end
      if (w_accept)                          r_adone <= 1'b0;
      else if (w_addr_act && r_cnt == '0)    r_adone <= 1'b1;
    end
  end
`else
  assign w_addr_act = (r_state == RUN);
  assign w_acc_act  = (r_state == RUN);
  assign w_acc_term = w_term;
  assign w_acc_msb  = (r_cnt == CNT_TOP);
  assign w_acc_last = (r_cnt == '0);
`endif

  // MSB plane carries negative weight (two's-complement samples).
  assign w_term_ext = {{(ACC_W-ROM_W-1){w_acc_term[ROM_W]}}, w_acc_term};
  assign w_acc_nxt  = (r_acc <<< 1) + (w_acc_msb ? -w_term_ext : w_term_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)                w_state_nxt = RUN;
      RUN:     if (w_acc_act && w_acc_last) w_state_nxt = DONE;
      DONE:    if (out_ready)               w_state_nxt = IDLE;
      default:                              w_state_nxt = IDLE;
    endcase
  end

  // Settle flag keeps in_ready low for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle    <= 1'b0;
      r_x         <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_settle <= 1'b1;
      if (w_accept) begin
        r_x   <= {x3, x2, x1, x0};
        r_cnt <= CNT_TOP;
        r_acc <= '0;
      end else begin
        if (w_addr_act && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        if (w_acc_act)                 r_acc <= w_acc_nxt;
      end
      if (w_acc_act && w_acc_last) begin
        r_result    <= w_acc_nxt;
        r_out_valid <= 1'b1;
      end else if (r_state == DONE && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
